// File: rtl/fractal_pkg.sv
// Shared defaults and FSM encoding for the Mandelbrot frame pipeline.
package fractal_pkg;

  localparam int unsigned DefCoordW = 27;
  localparam int unsigned DefAddrW  = 19;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StDispatch = 3'd2,
    StDrain    = 3'd3,
    StDone     = 3'd4
  } disp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant_onehot,
  output logic [IdxW-1:0] grant_idx,
  output logic            any
);

  logic [2*N-1:0] masked;

  always_comb begin
    // Upper copy covers lanes >= ptr, lower copy supplies the wrap-around.
    masked    = {req, req} & ({(2*N){1'b1}} << ptr);
    grant_idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) grant_idx = (i >= int'(N)) ? IdxW'(i - int'(N)) : IdxW'(i);
    end
    any          = |req;
    grant_onehot = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Walks one frame's pixel grid in raster order and hands coordinates to solvers round-robin.
module frame_dispatcher #(
  parameter int unsigned NUM_SOLVERS = 29,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned COORD_W     = fractal_pkg::DefCoordW,
  parameter int unsigned ADDR_W      = fractal_pkg::DefAddrW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] min_x,
  input  logic signed [COORD_W-1:0] min_y,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic [NUM_SOLVERS-1:0]    solver_ready,
  input  logic [NUM_SOLVERS-1:0]    solver_idle,
  output logic [NUM_SOLVERS-1:0]    job_valid,
  output logic signed [COORD_W-1:0] job_x,
  output logic signed [COORD_W-1:0] job_y,
  output logic [ADDR_W-1:0]         job_addr,
  output logic                      busy,
  output logic                      frame_done,
  output logic [31:0]               solve_time
);
  import fractal_pkg::*;

  localparam int unsigned PtrW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ColW-1:0]   LastCol  = ColW'(WIDTH - 1);
  localparam logic [PtrW-1:0]   LastLane = PtrW'(NUM_SOLVERS - 1);

  disp_state_e state_q, state_d;
  logic signed [COORD_W-1:0] min_x_q, min_x_d, dx_q, dx_d, dy_q, dy_d;
  logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [31:0]       timer_q, timer_d, solve_time_q, solve_time_d, timer_inc;

  logic [NUM_SOLVERS-1:0] grant_onehot;
  logic [PtrW-1:0]        grant_idx;
  logic                   grant_any;

  rr_arbiter #(
    .N    (NUM_SOLVERS),
    .IdxW (PtrW)
  ) u_arb (
    .req          (solver_ready),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    min_x_d      = min_x_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    x_d          = x_q;
    y_d          = y_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    solve_time_d = solve_time_q;
    job_valid    = '0;

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        min_x_d = min_x;
        dx_d    = dx;
        dy_d    = dy;
        x_d     = min_x;
        y_d     = min_y;
        col_d   = '0;
        row_d   = '0;
        addr_d  = '0;
        timer_d = 32'd1;  // cleared, then this LOAD cycle counted
        state_d = StDispatch;
      end
      StDispatch: begin
        timer_d = timer_inc;
        if (!start) begin
          job_valid = grant_onehot;
          if (grant_any) begin
            ptr_d = (grant_idx == LastLane) ? '0 : grant_idx + PtrW'(1);
            // Raster counters hold on the final pixel so they never leave the grid.
            if (addr_q == LastAddr) begin
              state_d = StDrain;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (col_q != LastCol) begin
                col_d = col_q + ColW'(1);
                x_d   = x_q + dx_q;
              end else begin
                col_d = '0;
                x_d   = min_x_q;
                row_d = row_q + RowW'(1);
                y_d   = y_q + dy_q;
              end
            end
          end
        end
      end
      StDrain: begin
        timer_d = timer_inc;
        if (&solver_idle) state_d = StDone;
      end
      StDone: begin
        solve_time_d = timer_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (start) state_d = StLoad;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      min_x_q      <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
      timer_q      <= '0;
      solve_time_q <= '0;
    end else begin
      state_q      <= state_d;
      min_x_q      <= min_x_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_q        <= col_d;
      row_q        <= row_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      solve_time_q <= solve_time_d;
    end
  end

  assign job_x      = x_q;
  assign job_y      = y_q;
  assign job_addr   = addr_q;
  assign solve_time = solve_time_q;
  assign frame_done = (state_q == StDone);
  assign busy       = (state_q == StLoad) || (state_q == StDispatch) || (state_q == StDrain);

endmodule

// File: tb/tb_frame_dispatcher.sv
// Randomized self-checking bench for frame_dispatcher on a 4x2 grid with 3 solver lanes.
module tb_frame_dispatcher;

  localparam int N    = 3;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CW   = 27;
  localparam int AW   = 3;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset, start;
  logic [CW-1:0] min_x, min_y, dx, dy;
  logic [N-1:0]  solver_ready, solver_idle, job_valid;
  logic [CW-1:0] job_x, job_y;
  logic [AW-1:0] job_addr;
  logic          busy, frame_done;
  logic [31:0]   solve_time;

  always #5 clock = ~clock;

  frame_dispatcher #(
    .NUM_SOLVERS (N),
    .WIDTH       (W),
    .HEIGHT      (H),
    .COORD_W     (CW),
    .ADDR_W      (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .min_x        (min_x),
    .min_y        (min_y),
    .dx           (dx),
    .dy           (dy),
    .solver_ready (solver_ready),
    .solver_idle  (solver_idle),
    .job_valid    (job_valid),
    .job_x        (job_x),
    .job_y        (job_y),
    .job_addr     (job_addr),
    .busy         (busy),
    .frame_done   (frame_done),
    .solve_time   (solve_time)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: next pixel index, round-robin pointer, frame parameters, busy cycles.
  int            m_ptr, m_k, m_cycles;
  logic [CW-1:0] m_min_x, m_min_y, m_dx, m_dy;

  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] rdy);
    for (int j = 0; j < N; j++) begin
      int i;
      i = (m_ptr + j) % N;
      if (rdy[i]) return N'(1 << i);
    end
    return '0;
  endfunction

  function automatic logic [CW-1:0] exp_x(input int k);
    logic [CW-1:0] c;
    c = CW'(k % W);
    return m_min_x + c * m_dx;
  endfunction

  function automatic logic [CW-1:0] exp_y(input int k);
    logic [CW-1:0] r;
    r = CW'(k / W);
    return m_min_y + r * m_dy;
  endfunction

  task automatic load_cycle();
    @(negedge clock);
    start    = 1'b0;
    m_min_x  = min_x;
    m_min_y  = min_y;
    m_dx     = dx;
    m_dy     = dy;
    m_k      = 0;
    m_cycles = 1;
  endtask

  task automatic begin_frame(input logic [CW-1:0] mx, input logic [CW-1:0] my,
                             input logic [CW-1:0] ddx, input logic [CW-1:0] ddy);
    @(negedge clock);
    start        = 1'b1;
    min_x        = mx;
    min_y        = my;
    dx           = ddx;
    dy           = ddy;
    solver_ready = '0;
    solver_idle  = '1;
    load_cycle();
  endtask

  task automatic test_dispatch_cycle(input logic [N-1:0] rdy, input string tag);
    logic [N-1:0] ev;
    @(negedge clock);
    start        = 1'b0;
    solver_ready = rdy;
    min_x        = CW'($urandom);
    min_y        = CW'($urandom);
    dx           = CW'($urandom);
    dy           = CW'($urandom);
    #1;
    m_cycles++;
    ev = (m_k < NPIX) ? exp_grant(rdy) : '0;
    tests_run++;
    if (job_valid !== ev) begin
      tests_failed++;
      $display("FAIL %s job_valid pix %0d: got %b want %b", tag, m_k, job_valid, ev);
    end
    if (m_k < NPIX) begin
      tests_run++;
      if (job_addr !== AW'(m_k)) begin
        tests_failed++;
        $display("FAIL %s job_addr: got %0d want %0d", tag, job_addr, m_k);
      end
      tests_run++;
      if (job_x !== exp_x(m_k)) begin
        tests_failed++;
        $display("FAIL %s job_x pix %0d: got %h want %h", tag, m_k, job_x, exp_x(m_k));
      end
      tests_run++;
      if (job_y !== exp_y(m_k)) begin
        tests_failed++;
        $display("FAIL %s job_y pix %0d: got %h want %h", tag, m_k, job_y, exp_y(m_k));
      end
    end
    tests_run++;
    if (busy !== 1'b1 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s status: got busy=%b done=%b want busy=1 done=0", tag, busy, frame_done);
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        m_ptr = (i + 1) % N;
        m_k++;
      end
    end
  endtask

  // Called right after the last transfer; lane 1 stays busy for 'hold' cycles.
  task automatic test_drain_done(input int hold, input string tag);
    for (int c = 0; c <= hold + 2; c++) begin
      @(negedge clock);
      solver_idle = (c < hold) ? 3'b101 : 3'b111;
      #1;
      tests_run++;
      if (c <= hold) begin
        m_cycles++;
        if (frame_done !== 1'b0 || busy !== 1'b1 || job_valid !== '0) begin
          tests_failed++;
          $display("FAIL %s drain c=%0d: got done=%b busy=%b valid=%b want 0,1,000",
                   tag, c, frame_done, busy, job_valid);
        end
      end else if (c == hold + 1) begin
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s done pulse: got done=%b busy=%b want 1,0", tag, frame_done, busy);
        end
      end else begin
        if (frame_done !== 1'b0 || solve_time !== 32'(m_cycles)) begin
          tests_failed++;
          $display("FAIL %s solve_time: got %0d done=%b want %0d done=0",
                   tag, solve_time, frame_done, m_cycles);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'b0;
    solver_ready = '1;
    solver_idle  = '1;
    min_x        = '0;
    min_y        = '0;
    dx           = '0;
    dy           = '0;
    repeat (3) @(negedge clock);
    #1;
    tests_run++;
    if (job_valid !== '0 || job_x !== '0 || job_y !== '0 || job_addr !== '0) begin
      tests_failed++;
      $display("FAIL reset job: got v=%b x=%h y=%h a=%0d want all 0",
               job_valid, job_x, job_y, job_addr);
    end
    tests_run++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || solve_time !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset status: got busy=%b done=%b time=%0d want 0,0,0",
               busy, frame_done, solve_time);
    end
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0;
    m_k   = NPIX;
  endtask

  task automatic test_raster();
    begin_frame(-27'sd8, 27'sd4, 27'sd2, -27'sd1);
    for (int i = 0; i < NPIX; i++) test_dispatch_cycle(3'b111, "raster");
    test_drain_done(0, "raster");
  endtask

  task automatic test_single_lane();
    begin_frame(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
    for (int i = 0; i < 4; i++) test_dispatch_cycle(3'b100, "lane2");
    for (int i = 0; i < 4; i++) test_dispatch_cycle(3'b011, "lane01");
    test_drain_done(10, "drain10");
  endtask

  task automatic test_stall();
    begin_frame(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
    for (int i = 0; i < 2; i++) test_dispatch_cycle(3'b111, "prestall");
    for (int i = 0; i < 5; i++) test_dispatch_cycle(3'b000, "stall");
    for (int i = 0; i < 6; i++) test_dispatch_cycle(3'b111, "resume");
    test_drain_done(3, "stall");
  endtask

  task automatic test_abort();
    begin_frame(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
    for (int i = 0; i < 3; i++) test_dispatch_cycle(3'b111, "preabort");
    @(negedge clock);
    start        = 1'b1;
    solver_ready = 3'b111;
    min_x        = 27'h0123456;
    #1;
    tests_run++;
    if (job_valid !== '0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort drop: got valid=%b done=%b want 000,0", job_valid, frame_done);
    end
    load_cycle();
    for (int i = 0; i < NPIX; i++) test_dispatch_cycle(3'b111, "reload");
    test_drain_done(1, "abort");
  endtask

  task automatic test_wrap_reset();
    begin_frame(27'h3FF_FFFF, CW'($urandom), 27'sd1, CW'($urandom));
    test_dispatch_cycle(3'b111, "wrap");
    @(negedge clock);
    solver_ready = 3'b000;
    #1;
    tests_run++;
    if (job_x !== 27'h400_0000) begin
      tests_failed++;
      $display("FAIL wrap x: got %h want 4000000", job_x);
    end
    solver_ready = 3'b111;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    tests_run++;
    if (job_valid !== '0 || job_x !== '0 || job_y !== '0 || job_addr !== '0 ||
        busy !== 1'b0 || frame_done !== 1'b0 || solve_time !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset: got v=%b x=%h y=%h a=%0d busy=%b done=%b t=%0d want all 0",
               job_valid, job_x, job_y, job_addr, busy, frame_done, solve_time);
    end
    @(negedge clock);
    reset = 1'b0;
    m_ptr = 0;
    m_k   = NPIX;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      tests_run++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL postreset idle: got done=%b busy=%b want 0,0", frame_done, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int guard;
      begin_frame(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom));
      guard = 0;
      while (m_k < NPIX && guard < 100) begin
        test_dispatch_cycle(N'($urandom_range(0, 7)), "random");
        guard++;
      end
      tests_run++;
      if (m_k < NPIX) begin
        tests_failed++;
        $display("FAIL random frame %0d: got %0d pixels want %0d", f, m_k, NPIX);
      end
      test_drain_done(int'($urandom_range(0, 4)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_single_lane();
    test_stall();
    test_abort();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
